// File: rtl/pic_hs_pkg.sv
// pic_hs_pkg: shared definitions for the PIC req/ack CDC handshake blocks.
//   hs_state_e    - transmitter FSM state encoding (IDLE/REQ/ACK)
//   DATA_W_DEF    - default handshake data width
//   SYNC_NUM_DEF  - default synchronizer depth on the returning acknowledge
`timescale 1ns/1ps
package pic_hs_pkg;
  localparam int DATA_W_DEF   = 8;
  localparam int SYNC_NUM_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    ACK  = 2'b10
  } hs_state_e;
endpackage

// File: rtl/pic_sync_dff.sv
// pic_sync_dff: multi-flop level synchronizer into the clk domain.
// Ports:
//   clk   - destination clock
//   rst_b - asynchronous active-low reset, clears every stage to 0
//   i_d   - asynchronous input level
//   o_q   - synchronized level, FLOP_NUM clk edges behind i_d
// FLOP_NUM must be at least 2.
`timescale 1ns/1ps
module pic_sync_dff #(
  parameter int FLOP_NUM = 2,
  parameter int WIDTH    = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [FLOP_NUM-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_sync <= '0;
    else        r_sync <= {r_sync[FLOP_NUM-2:0], i_d};
  end

  assign o_q = r_sync[FLOP_NUM-1];
endmodule

// File: rtl/pic_hs_cdc_tx.sv
// pic_hs_cdc_tx: source side of a 4-phase req/ack clock-domain crossing.
// Takes one word from a valid/ready producer, holds it on hs_data, raises
// hs_req, waits for the synchronized ack to rise and fall again, then
// reports completion with a one-cycle tx_done.
// Ports:
//   clk, rst_b  - source clock, asynchronous active-low reset
//   tx_vld      - producer has a word
//   tx_data     - producer word, captured when tx_vld && tx_rdy
//   tx_rdy      - block can accept a word this cycle
//   tx_done     - one-cycle pulse, previous transfer fully completed
//   hs_req      - registered request level to the destination domain
//   hs_data     - registered data, stable while a transfer is outstanding
//   hs_ack      - acknowledge level from the destination (asynchronous)
//   tx_timeout  - one-cycle stall pulse (only with the timeout option)
// Build option: define PIC_HS_CDC_TX_TIMEOUT_EN to add a TO_W-bit stall
// counter; otherwise tx_timeout is tied low and TO_W has no effect.
`timescale 1ns/1ps
module pic_hs_cdc_tx
  import pic_hs_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SYNC_NUM = SYNC_NUM_DEF,
  parameter int TO_W     = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              tx_vld,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_rdy,
  output logic              tx_done,
  output logic              hs_req,
  output logic [DATA_W-1:0] hs_data,
  input  logic              hs_ack,
  output logic              tx_timeout
);
  hs_state_e         r_state;
  logic              r_req;
  logic              r_done;
  logic [DATA_W-1:0] r_data;
  logic              w_ack_s;
  logic              w_accept;

  pic_sync_dff #(
    .FLOP_NUM (SYNC_NUM),
    .WIDTH    (1)
  ) u_ack_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .i_d   (hs_ack),
    .o_q   (w_ack_s)
  );

  // A stale ack still high from a previous transfer blocks acceptance until
  // it has been seen low, so the destination never sees req rise into ack=1.
  assign tx_rdy   = (r_state == IDLE) && !w_ack_s;
  assign w_accept = tx_vld && tx_rdy;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= REQ;
          r_req   <= 1'b1;
          r_data  <= tx_data;
        end
        REQ: if (w_ack_s) begin
          r_state <= ACK;
          r_req   <= 1'b0;
        end
        ACK: if (!w_ack_s) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign hs_req  = r_req;
  assign hs_data = r_data;
  assign tx_done = r_done;

`ifdef PIC_HS_CDC_TX_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_to;
  logic [TO_W-1:0] w_to_inc;
  logic            w_state_chg;

  assign w_to_inc    = r_to_cnt + TO_W'(1);
  assign w_state_chg = ((r_state == IDLE) && w_accept) ||
                       ((r_state == REQ)  && w_ack_s)  ||
                       ((r_state == ACK)  && !w_ack_s);

  // The counter wraps straight from all-ones-minus-one to 0 while pulsing,
  // giving a period of 2^TO_W-1 cycles spent waiting in REQ or ACK.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_to_cnt <= '0;
      r_to     <= 1'b0;
    end else begin
      r_to <= 1'b0;
      if (w_state_chg || (r_state == IDLE)) begin
        r_to_cnt <= '0;
      end else if (w_to_inc == {TO_W{1'b1}}) begin
        r_to_cnt <= '0;
        r_to     <= 1'b1;
      end else begin
        r_to_cnt <= w_to_inc;
      end
    end
  end

  assign tx_timeout = r_to;
`else
  // TO_W only sizes the stall counter; without it the output is a constant 0.
  assign tx_timeout = 1'b0 & (TO_W == 0);
`endif
endmodule

// File: tb/tb_pic_hs_cdc_tx.sv
`timescale 1ns/1ps
module tb_pic_hs_cdc_tx;
  localparam int DATA_W   = 8;
  localparam int SYNC_NUM = 3;
  localparam int TO_W     = 4;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic              tx_vld = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_rdy, tx_done, hs_req, tx_timeout;
  logic [DATA_W-1:0] hs_data;
  logic              hs_ack;

  // Destination stand-in: either an automatic responder or a forced level.
  logic auto_ack  = 1'b0;
  logic dest_ack  = 1'b0;
  logic force_ack = 1'b0;
  int   dest_dly  = 0;
  assign hs_ack = auto_ack ? dest_ack : force_ack;

  pic_hs_cdc_tx #(
    .DATA_W   (DATA_W),
    .SYNC_NUM (SYNC_NUM),
    .TO_W     (TO_W)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .tx_vld     (tx_vld),
    .tx_data    (tx_data),
    .tx_rdy     (tx_rdy),
    .tx_done    (tx_done),
    .hs_req     (hs_req),
    .hs_data    (hs_data),
    .hs_ack     (hs_ack),
    .tx_timeout (tx_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [DATA_W-1:0] exp_q[$];
  int exp_rises = 0, exp_done = 0;
  int req_rises = 0, done_cnt = 0, to_cnt = 0, mon_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Destination: raise ack dest_dly cycles after seeing req, drop it once req falls.
  initial begin
    int dcnt;
    dcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!auto_ack) begin
        dest_ack = 1'b0;
        dcnt = 0;
      end else begin
        if (!hs_req) dcnt = 0;
        if (hs_req && !dest_ack) begin
          if (dcnt >= dest_dly) dest_ack = 1'b1;
          else dcnt++;
        end else if (!hs_req && dest_ack) begin
          dest_ack = 1'b0;
        end
      end
    end
  end

  // Scoreboard / protocol watcher: words appear in order, data held while
  // requesting, no readiness during a request, tx_done never wider than 1.
  initial begin
    logic pr, pd;
    logic [DATA_W-1:0] pdata, w;
    pr = 1'b0; pd = 1'b0; pdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hs_req && !pr) begin
        req_rises++;
        if (exp_q.size() == 0) begin
          mon_err++;
          $display("monitor: request with no offered word, data %0h", hs_data);
        end else begin
          w = exp_q.pop_front();
          if (hs_data !== w) begin
            mon_err++;
            $display("monitor: request data %0h, offered word %0h", hs_data, w);
          end
        end
      end
      if (pr && hs_req && (hs_data !== pdata)) begin
        mon_err++;
        $display("monitor: hs_data moved during request %0h -> %0h", pdata, hs_data);
      end
      if (hs_req && tx_rdy) begin
        mon_err++;
        $display("monitor: tx_rdy high while hs_req high");
      end
      if (tx_done && pd) begin
        mon_err++;
        $display("monitor: tx_done held more than one cycle");
      end
      if (tx_done) done_cnt++;
      if (tx_timeout) to_cnt++;
      pr = hs_req; pd = tx_done; pdata = hs_data;
    end
  end

  // One full transfer with an auto-acking destination; leaves the bench at
  // the sample where tx_done is seen, so a following call is back-to-back.
  task automatic xfer(input logic [DATA_W-1:0] word, input int dly, input bit junk);
    int n;
    bit rdy_bad;
    n = 0; rdy_bad = 1'b0;
    dest_dly = dly;
    auto_ack = 1'b1;
    chk("rdy_before_offer", tx_rdy, 1);
    tx_vld = 1'b1;
    tx_data = word;
    exp_q.push_back(word);
    exp_rises++;
    step();
    chk("req_at_T1", hs_req, 1);
    chk("data_at_T1", hs_data, word);
    tx_vld = 1'b0;
    do begin
      if (junk) begin
        tx_vld  = 1'($urandom_range(0, 1));
        tx_data = DATA_W'($urandom);
      end
      step();
      n++;
      if (!tx_done && tx_rdy) rdy_bad = 1'b1;
    end while (!tx_done && n < 100);
    tx_vld = 1'b0;
    chk("done_seen", tx_done, 1);
    chk("loop_cycles", n, 2*SYNC_NUM + 2 + dly);
    chk("rdy_low_in_loop", rdy_bad, 0);
    chk("rdy_after_done", tx_rdy, 1);
    chk("data_held", hs_data, word);
    exp_done++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0;
    logic [DATA_W-1:0] word;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hs_req", hs_req, 0);
    chk("rst_hs_data", hs_data, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx_timeout", tx_timeout, 0);
    #3 rst_b = 1'b1;
    step();
    chk("post_rst_rdy", tx_rdy, 1);
    chk("post_rst_req", hs_req, 0);

    // Single transfer, ack two cycles after req
    xfer(8'hA5, 2, 1'b0);
    step();
    chk("single_done_pulse_end", tx_done, 0);
    chk("single_data_kept", hs_data, 8'hA5);

    // Back-to-back with tx_vld held
    r0 = req_rises;
    xfer(8'h01, 0, 1'b0);
    xfer(8'h02, 0, 1'b0);
    xfer(8'h03, 0, 1'b0);
    chk("b2b_req_cnt", req_rises - r0, 3);

    // Randomized words, ack delays, idle gaps and ignored producer noise
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) step();
      word = DATA_W'($urandom);
      xfer(word, int'($urandom_range(0, 4)), 1'b1);
    end
    step();

    // Stale ack in IDLE
    auto_ack = 1'b0;
    force_ack = 1'b1;
    repeat (SYNC_NUM) step();
    chk("stale_rdy_low", tx_rdy, 0);
    r0 = req_rises;
    tx_vld = 1'b1;
    tx_data = 8'hEE;
    repeat (4) step();
    chk("stale_no_req", hs_req, 0);
    chk("stale_no_accept", req_rises - r0, 0);
    tx_vld = 1'b0;
    force_ack = 1'b0;
    step();
    step();
    chk("stale_rdy_2", tx_rdy, 0);
    step();
    chk("stale_rdy_3", tx_rdy, 1);

    // Reset in the middle of REQ
    tx_vld = 1'b1;
    tx_data = 8'h5C;
    exp_q.push_back(8'h5C);
    exp_rises++;
    step();
    chk("mid_req_up", hs_req, 1);
    tx_vld = 1'b0;
    step();
    step();
    #3 rst_b = 1'b0;
    #1;
    chk("mid_rst_req", hs_req, 0);
    chk("mid_rst_data", hs_data, 0);
    chk("mid_rst_done", tx_done, 0);
    d0 = done_cnt;
    #2 rst_b = 1'b1;
    repeat (12) step();
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_rdy", tx_rdy, 1);

`ifdef PIC_HS_CDC_TX_TIMEOUT_EN
    // Never-acked request: stall pulse every 2^TO_W-1 cycles, no abort
    begin
      int p15, p30, other;
      p15 = 0; p30 = 0; other = 0;
      tx_vld = 1'b1;
      tx_data = 8'h3A;
      exp_q.push_back(8'h3A);
      exp_rises++;
      step();
      tx_vld = 1'b0;
      for (int k = 1; k <= 31; k++) begin
        step();
        if (tx_timeout) begin
          if (k == 15) p15++;
          else if (k == 30) p30++;
          else other++;
        end
      end
      chk("to_pulse_15", p15, 1);
      chk("to_pulse_30", p30, 1);
      chk("to_pulse_other", other, 0);
      chk("to_req_held", hs_req, 1);
      #3 rst_b = 1'b0;
      #4 rst_b = 1'b1;
      step();
    end
`endif

    // Totals from the watcher
    chk("mon_err", mon_err, 0);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("req_total", req_rises, exp_rises);
    chk("done_total", done_cnt, exp_done);
`ifdef PIC_HS_CDC_TX_TIMEOUT_EN
    chk("to_total", to_cnt, 2);
`else
    chk("to_total", to_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
